// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - stage/butterfly sequencer for an in-place radix-2 DIT FFT
// Purpose: walks N_LOG2 stages x N/2 butterflies, issuing p/q read addresses,
//   twiddle index and butterfly enable, and delays them so the write-back
//   addresses line up with butterfly vld. Drains between stages.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start                    run request, sampled only in IDLE
//   busy, done               run in progress / one-cycle completion pulse
//   stage                    current read-side stage index
//   rd_en, rd_addr_p/q       RAM read strobe and butterfly top/bottom addresses
//   tw_addr                  twiddle ROM index
//   bf_en                    butterfly enable (rd_en delayed RD_LAT)
//   wr_en, wr_addr_p/q       write-back strobe/addresses (delayed RD_LAT+BF_LAT)
//   inverse, tw_conj         only with FFT_CTRL_INVERSE_EN: IFFT request captured
//                            with start, conjugate-twiddle flag aligned with bf_en
// Optional feature macro: FFT_CTRL_INVERSE_EN
module fft_stage_ctrl #(
  parameter int N_LOG2 = 8,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
`ifdef FFT_CTRL_INVERSE_EN
  input  logic                      inverse,
  output logic                      tw_conj,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N_LOG2)-1:0] stage,
  output logic                      rd_en,
  output logic [N_LOG2-1:0]         rd_addr_p,
  output logic [N_LOG2-1:0]         rd_addr_q,
  output logic [N_LOG2-2:0]         tw_addr,
  output logic                      bf_en,
  output logic                      wr_en,
  output logic [N_LOG2-1:0]         wr_addr_p,
  output logic [N_LOG2-1:0]         wr_addr_q
);
  localparam int SW  = $clog2(N_LOG2);
  localparam int KW  = N_LOG2 - 1;
  localparam int LAT = RD_LAT + BF_LAT;
  localparam int CW  = $clog2(LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // Between stages the drain is one cycle longer than the pipeline depth, so
  // the last stage-s write has been committed a full cycle before stage s+1
  // issues its first read. After the final stage only the pipeline must empty.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          stage_d = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (k_q == {KW{1'b1}}) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (stage_q == SW'(N_LOG2 - 1)) begin
          if (cnt_q == CW'(LAT - 1)) state_d = S_DONE;
        end else if (cnt_q == CW'(LAT)) begin
          state_d = S_RUN;
          stage_d = stage_q + 1'b1;
          k_d     = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
        k_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_en = (state_q == S_RUN);
  assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done  = (state_q == S_DONE);
  assign stage = stage_q;

  // p is k with a zero bit inserted at position stage; q sets that bit.
  logic [N_LOG2-1:0] k_ext, lo_mask, pos, addr_p;
  assign k_ext   = {1'b0, k_q};
  assign lo_mask = (N_LOG2'(1) << stage_q) - N_LOG2'(1);
  assign pos     = k_ext & lo_mask;
  assign addr_p  = ((k_ext & ~lo_mask) << 1) | pos;

  // Addresses are forced to zero while the strobe is low so they never
  // wander between accesses and the delayed copies inherit the same rule.
  assign rd_addr_p = rd_en ? addr_p : '0;
  assign rd_addr_q = rd_en ? (addr_p | (N_LOG2'(1) << stage_q)) : '0;
  assign tw_addr   = rd_en ? (pos[KW-1:0] << (SW'(N_LOG2 - 1) - stage_q)) : '0;

  logic [LAT:1]      en_sr_q;
  logic [N_LOG2-1:0] ap_sr_q [1:LAT];
  logic [N_LOG2-1:0] aq_sr_q [1:LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_sr_q <= '0;
      for (int i = 1; i <= LAT; i++) begin
        ap_sr_q[i] <= '0;
        aq_sr_q[i] <= '0;
      end
    end else begin
      en_sr_q[1] <= rd_en;
      ap_sr_q[1] <= rd_addr_p;
      aq_sr_q[1] <= rd_addr_q;
      for (int i = 2; i <= LAT; i++) begin
        en_sr_q[i] <= en_sr_q[i-1];
        ap_sr_q[i] <= ap_sr_q[i-1];
        aq_sr_q[i] <= aq_sr_q[i-1];
      end
    end
  end

  assign bf_en     = en_sr_q[RD_LAT];
  assign wr_en     = en_sr_q[LAT];
  assign wr_addr_p = ap_sr_q[LAT];
  assign wr_addr_q = aq_sr_q[LAT];

`ifdef FFT_CTRL_INVERSE_EN
  logic              inv_q;
  logic [RD_LAT:1]   conj_sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q     <= 1'b0;
      conj_sr_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) inv_q <= inverse;
      conj_sr_q[1] <= rd_en & inv_q;
      for (int i = 2; i <= RD_LAT; i++) conj_sr_q[i] <= conj_sr_q[i-1];
    end
  end

  assign tw_conj = conj_sr_q[RD_LAT];
`endif
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb/tb_fft_stage_ctrl.sv - self-checking bench for fft_stage_ctrl against a schedule/address model
module tb_fft_stage_ctrl;
  localparam int N_LOG2   = 8;
  localparam int RD_LAT   = 1;
  localparam int BF_LAT   = 3;
  localparam int LAT      = RD_LAT + BF_LAT;
  localparam int NB       = 1 << (N_LOG2 - 1);
  localparam int PER      = NB + LAT + 1;
  localparam int LAST_WR  = 1 + PER * (N_LOG2 - 1) + NB - 1 + LAT;
  localparam int DONE_CYC = LAST_WR + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, rd_en, bf_en, wr_en;
  logic [2:0]        stage;
  logic [N_LOG2-1:0] rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q;
  logic [N_LOG2-2:0] tw_addr;
`ifdef FFT_CTRL_INVERSE_EN
  logic              inverse_drv = 1'b0;
  logic              tw_conj;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int pend [256];

  fft_stage_ctrl #(.N_LOG2(N_LOG2), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef FFT_CTRL_INVERSE_EN
    .inverse   (inverse_drv),
    .tw_conj   (tw_conj),
`endif
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_p (rd_addr_p),
    .rd_addr_q (rd_addr_q),
    .tw_addr   (tw_addr),
    .bf_en     (bf_en),
    .wr_en     (wr_en),
    .wr_addr_p (wr_addr_p),
    .wr_addr_q (wr_addr_q)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference schedule: cycle c (c=1 is the cycle after the start edge) is a
  // read cycle when it lands in the first NB slots of a PER-cycle stage window.
  function automatic bit model_rd(input int c, output int s, output int p,
                                  output int q, output int tw);
    int k, h, grp, pos;
    s = 0; p = 0; q = 0; tw = 0;
    if (c < 1) return 1'b0;
    s = (c - 1) / PER;
    k = (c - 1) % PER;
    if (s >= N_LOG2 || k >= NB) return 1'b0;
    h   = 1 << s;
    grp = k / h;
    pos = k % h;
    p   = grp * 2 * h + pos;
    q   = p + h;
    tw  = pos * (NB / h);
    return 1'b1;
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rd_en"}, rd_en, 0);
    check({pfx, "_bf_en"}, bf_en, 0);
    check({pfx, "_wr_en"}, wr_en, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_stage"}, stage, 0);
    check({pfx, "_rd_addr_p"}, rd_addr_p, 0);
    check({pfx, "_rd_addr_q"}, rd_addr_q, 0);
    check({pfx, "_tw_addr"}, tw_addr, 0);
    check({pfx, "_wr_addr_p"}, wr_addr_p, 0);
    check({pfx, "_wr_addr_q"}, wr_addr_q, 0);
`ifdef FFT_CTRL_INVERSE_EN
    check({pfx, "_tw_conj"}, tw_conj, 0);
`endif
  endtask

  task automatic run_fft(input bit noise, input bit inv);
    int  s0, p0, q0, t0, s1, p1, q1, t1, s4, p4, q4, t4;
    bit  er, eb, ew;
    int  n_wr, n_done;
    n_wr = 0;
    n_done = 0;
    foreach (pend[i]) pend[i] = 0;
    @(negedge clk);
    start = 1'b1;
`ifdef FFT_CTRL_INVERSE_EN
    inverse_drv = inv;
`else
    if (inv) n_wr = 0;
`endif
    for (int c = 1; c <= DONE_CYC + 6; c++) begin
      @(posedge clk);
      #1;
      start = (c == 50) || (c == DONE_CYC) ||
              (noise && c <= DONE_CYC && ($urandom % 8 == 0));
`ifdef FFT_CTRL_INVERSE_EN
      inverse_drv = 1'($urandom % 2);
`endif
      @(negedge clk);
      er = model_rd(c, s0, p0, q0, t0);
      eb = model_rd(c - RD_LAT, s1, p1, q1, t1);
      ew = model_rd(c - LAT, s4, p4, q4, t4);
      check("rd_en", rd_en, er);
      check("bf_en", bf_en, eb);
      check("wr_en", wr_en, ew);
      check("busy", busy, c <= LAST_WR);
      check("done", done, c == DONE_CYC);
      if (er) begin
        check("stage", stage, s0);
        check("rd_addr_p", rd_addr_p, p0);
        check("rd_addr_q", rd_addr_q, q0);
        check("tw_addr", tw_addr, t0);
      end
      if (ew) begin
        check("wr_addr_p", wr_addr_p, p4);
        check("wr_addr_q", wr_addr_q, q4);
      end
`ifdef FFT_CTRL_INVERSE_EN
      if (eb) check("tw_conj", tw_conj, inv);
`endif
      if (c == 1 + 5) begin
        check("s0k5_p", rd_addr_p, 10);
        check("s0k5_q", rd_addr_q, 11);
        check("s0k5_tw", tw_addr, 0);
      end
      if (c == 1 + 3 * PER + 13) begin
        check("s3k13_p", rd_addr_p, 21);
        check("s3k13_q", rd_addr_q, 29);
        check("s3k13_tw", tw_addr, 80);
      end
      if (c == 1 + 7 * PER + 127) begin
        check("s7k127_p", rd_addr_p, 127);
        check("s7k127_q", rd_addr_q, 255);
        check("s7k127_tw", tw_addr, 127);
      end
      // Read-after-write hazard scoreboard driven by the DUT's own strobes.
      if (rd_en === 1'b1) begin
        check("raw_hazard_p", pend[int'(rd_addr_p)], 0);
        check("raw_hazard_q", pend[int'(rd_addr_q)], 0);
        pend[int'(rd_addr_p)]++;
        pend[int'(rd_addr_q)]++;
      end
      if (wr_en === 1'b1) begin
        pend[int'(wr_addr_p)]--;
        pend[int'(wr_addr_q)]--;
        n_wr++;
      end
      if (done === 1'b1) n_done++;
    end
    start = 1'b0;
    check("wr_count", n_wr, N_LOG2 * NB);
    check("done_count", n_done, 1);
  endtask

  task automatic reset_mid_run();
    int stop_c, s, p, q, t;
    stop_c = 1 + 3 * PER + int'($urandom_range(5, 120));
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= stop_c; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(negedge clk);
    check("pre_rst_rd_en", rd_en, model_rd(stop_c, s, p, q, t));
    check("pre_rst_stage", stage, 3);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("post_rst_rd_en", rd_en, 0);
      check("post_rst_wr_en", wr_en, 0);
      check("post_rst_busy", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat ($urandom_range(1, 5)) begin
      @(negedge clk);
      check("idle_rd_en", rd_en, 0);
    end
    run_fft(1'b1, 1'b1);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    run_fft(1'b1, 1'b0);
    reset_mid_run();
    run_fft(1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
